noc_m1_ni_wr: RTL

Write-path network interface for master port M1. It is an AXI4 write slave that accepts one AW/W burst at a time from the M1 master, packetizes it into a header flit plus one data flit per beat, and returns the B response. It sits directly downstream of the M1 AXI master, whose AW/W/B signals it consumes, and directly upstream of the NoC router injection port.

---
 rtl/noc_ni_pkg.sv | 49 ++++
 rtl/noc_flit_out_reg.sv | 27 ++
 rtl/noc_m1_ni_wr.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/noc_ni_pkg.sv
// Shared types and constants for the NoC network-interface write/read paths.
package noc_ni_pkg;

   localparam int unsigned ID_W        = 4;
   localparam int unsigned LEN_W       = 4;
   localparam int unsigned SIZE_W      = 3;
   localparam int unsigned BURST_W     = 2;
   localparam int unsigned SRC_W       = 4;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned STRB_W      = 4;
   // Decodable addresses fit in 28 bits, so the header only carries those.
   localparam int unsigned HDR_ADDR_W  = 28;
   localparam int unsigned FLIT_BASE_W = 48;

   localparam logic [1:0] FLIT_HDR    = 2'b01;
   localparam logic [1:0] FLIT_DATA   = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      DATA  = 3'd2,
      DRAIN = 3'd3,
      RESP  = 3'd4
   } wr_state_t;

   typedef struct packed {
      logic [1:0]            ftype;
      logic [SRC_W-1:0]      src;
      logic [ID_W-1:0]       id;
      logic [LEN_W-1:0]      len;
      logic [SIZE_W-1:0]     size;
      logic [BURST_W-1:0]    burst;
      logic [HDR_ADDR_W-1:0] addr;
      logic                  pad;
   } hdr_flit_t;

   typedef struct packed {
      logic [1:0]        ftype;
      logic              last;
      logic [STRB_W-1:0] strb;
      logic [8:0]        rsvd;
      logic [DATA_W-1:0] data;
   } data_flit_t;

endpackage

// File: rtl/noc_flit_out_reg.sv
// One-entry valid/ready output register feeding a router injection port.
module noc_flit_out_reg #(
   parameter int unsigned W = 48
) (
   input  logic         ACLK,
   input  logic         ARESET,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data
);

   // Load wins over drain so a new flit can replace one accepted this cycle.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/noc_m1_ni_wr.sv
// Write-path NI for master M1: AXI4 write slave to header + data flits, returns B.
module noc_m1_ni_wr #(
   parameter logic [31:0] ADDR_MAX = 32'h0FFF_FFFF,
   parameter int unsigned FLIT_W   = 48,
   parameter logic [3:0]  SRC_ID   = 4'd1
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              M1_AWVALID,
   output logic              M1_AWREADY,
   input  logic [31:0]       M1_AWADDR,
   input  logic [3:0]        M1_AWID,
   input  logic [3:0]        M1_AWLEN,
   input  logic [2:0]        M1_AWSIZE,
   input  logic [1:0]        M1_AWBURST,
   input  logic              M1_WVALID,
   output logic              M1_WREADY,
   input  logic [31:0]       M1_WDATA,
   input  logic [3:0]        M1_WSTRB,
   input  logic              M1_WLAST,
   output logic              M1_BVALID,
   input  logic              M1_BREADY,
   output logic [1:0]        M1_BRESP,
   output logic [3:0]        M1_BID,
   output logic              FLIT_VALID,
   input  logic              FLIT_READY,
   output logic [FLIT_W-1:0] FLIT_DATA
);
   import noc_ni_pkg::*;

   // Flits are left-aligned so the type code is always in the top two bits.
   localparam int unsigned FLIT_PAD = FLIT_W - FLIT_BASE_W;

   wr_state_t         state;
   logic              awready_q;
   logic              bvalid_q;
   logic [1:0]        bresp_q;
   logic [ID_W-1:0]   bid_q;
   logic [ID_W-1:0]   id_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  beat_cnt;
   logic              err_q;
   logic              last_sent;

   logic              aw_hs;
   logic              dec_fail;
   logic              w_hs;
   logic              beat_last;
   logic              flit_acc;
   logic              flit_load;
   logic [FLIT_W-1:0] flit_load_data;
   hdr_flit_t         hdr_flit;
   data_flit_t        dat_flit;

   assign aw_hs      = (state == IDLE) && awready_q && M1_AWVALID;
   assign dec_fail   = M1_AWADDR > ADDR_MAX;
   assign w_hs       = M1_WVALID && M1_WREADY;
   assign beat_last  = beat_cnt == len_q;
   assign flit_acc   = FLIT_VALID && FLIT_READY;

   assign M1_AWREADY = awready_q;
   assign M1_BVALID  = bvalid_q;
   assign M1_BRESP   = bresp_q;
   assign M1_BID     = bid_q;

   // W acceptance: gated by the flit register in DATA, free-running in DRAIN.
   always_comb begin
      M1_WREADY = 1'b0;
      case (state)
         DATA:    M1_WREADY = !last_sent && (!FLIT_VALID || FLIT_READY);
         DRAIN:   M1_WREADY = 1'b1;
         default: M1_WREADY = 1'b0;
      endcase
   end

   // Header comes straight from the AW inputs so it is valid the cycle after AW.
   always_comb begin
      hdr_flit       = '0;
      hdr_flit.ftype = FLIT_HDR;
      hdr_flit.src   = SRC_ID;
      hdr_flit.id    = M1_AWID;
      hdr_flit.len   = M1_AWLEN;
      hdr_flit.size  = M1_AWSIZE;
      hdr_flit.burst = M1_AWBURST;
      hdr_flit.addr  = M1_AWADDR[HDR_ADDR_W-1:0];
      hdr_flit.pad   = 1'b0;

      dat_flit       = '0;
      dat_flit.ftype = noc_ni_pkg::FLIT_DATA;
      dat_flit.last  = beat_last;
      dat_flit.strb  = M1_WSTRB;
      dat_flit.rsvd  = 9'd0;
      dat_flit.data  = M1_WDATA;

      flit_load      = (aw_hs && !dec_fail) || ((state == DATA) && w_hs);
      flit_load_data = aw_hs ? (FLIT_W'(hdr_flit) << FLIT_PAD)
                             : (FLIT_W'(dat_flit) << FLIT_PAD);
   end

   noc_flit_out_reg #(.W(FLIT_W)) u_flit_out (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .load      (flit_load),
      .load_data (flit_load_data),
      .ready     (FLIT_READY),
      .valid     (FLIT_VALID),
      .data      (FLIT_DATA)
   );

   // Burst sequencing: one outstanding write, beat counting, B generation.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state     <= IDLE;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         bid_q     <= '0;
         id_q      <= '0;
         len_q     <= '0;
         beat_cnt  <= '0;
         err_q     <= 1'b0;
         last_sent <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               awready_q <= 1'b1;
               if (aw_hs) begin
                  awready_q <= 1'b0;
                  id_q      <= M1_AWID;
                  len_q     <= M1_AWLEN;
                  beat_cnt  <= '0;
                  err_q     <= 1'b0;
                  last_sent <= 1'b0;
                  state     <= dec_fail ? DRAIN : HDR;
               end
            end
            HDR: begin
               if (flit_acc) state <= DATA;
            end
            DATA: begin
               if (w_hs) begin
                  if (M1_WLAST != beat_last) err_q <= 1'b1;
                  if (beat_last) last_sent <= 1'b1;
                  else           beat_cnt  <= beat_cnt + LEN_W'(1);
               end
               // No loads after the last beat, so this acceptance is the tail flit.
               if (last_sent && flit_acc) begin
                  state    <= RESP;
                  bvalid_q <= 1'b1;
                  bid_q    <= id_q;
                  bresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
               end
            end
            DRAIN: begin
               if (w_hs) begin
                  if (beat_last) begin
                     state    <= RESP;
                     bvalid_q <= 1'b1;
                     bid_q    <= id_q;
                     bresp_q  <= RESP_DECERR;
                  end else begin
                     beat_cnt <= beat_cnt + LEN_W'(1);
                  end
               end
            end
            RESP: begin
               if (M1_BREADY) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
